video_timing_gen: RTL and testbench

Parametrised raster timing generator: successor to the fixed 640x480 sync generator and its divided-clock chain.
- Runs on one system clock and derives the pixel rate as a clock-enable, not as a divided clock.
- Produces programmable-polarity hsync/vsync, blank, pixel coordinates, line/frame/vblank event pulses and a frame counter.
- Sits between the top-level clocking and the GPU scan-out/VGA pins.

---
 rtl/video_timing_pkg.sv | 36 +++
 rtl/pixel_ce_divider.sv | 31 +++
 rtl/video_timing_gen.sv | 108 ++++++++++
 tb/tb_video_timing_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: raster timing descriptions shared by the timing generator and its users.
package video_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_t;

    typedef struct packed {
        axis_t h;
        axis_t v;
        logic  hs_act;
        logic  vs_act;
    } timing_t;

    localparam timing_t VGA_640x480_60 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2, bp: 33},
        hs_act: 1'b0,
        vs_act: 1'b0
    };

    localparam timing_t TEST_8x6 = '{
        h: '{active: 4, fp: 1, sync: 2, bp: 1},
        v: '{active: 3, fp: 1, sync: 1, bp: 1},
        hs_act: 1'b1,
        vs_act: 1'b1
    };

    function automatic int axis_total(axis_t a);
        return a.active + a.fp + a.sync + a.bp;
    endfunction

endpackage

// File: rtl/pixel_ce_divider.sv
// pixel_ce_divider: derives a one-clk pixel enable every CLK_DIV system clocks.
// tick is the unregistered form of pix_ce so the raster counters can advance in the same edge.
module pixel_ce_divider
    import video_timing_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic tick,
    output logic pix_ce
);

    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;

    assign tick = enable && div_cnt == DW'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
            pix_ce  <= 1'b0;
        end else begin
            div_cnt <= (!enable || tick) ? '0 : div_cnt + 1'b1;
            pix_ce  <= tick;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator driven by a pixel clock-enable.
// All outputs are decoded from the next position so they align with current_x/current_y.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   CLK_DIV  = 4,
    parameter int   H_ACTIVE = VGA_640x480_60.h.active,
    parameter int   H_FP     = VGA_640x480_60.h.fp,
    parameter int   H_SYNC   = VGA_640x480_60.h.sync,
    parameter int   H_BP     = VGA_640x480_60.h.bp,
    parameter int   V_ACTIVE = VGA_640x480_60.v.active,
    parameter int   V_FP     = VGA_640x480_60.v.fp,
    parameter int   V_SYNC   = VGA_640x480_60.v.sync,
    parameter int   V_BP     = VGA_640x480_60.v.bp,
    parameter logic HS_ACT   = VGA_640x480_60.hs_act,
    parameter logic VS_ACT   = VGA_640x480_60.vs_act,
    parameter int   COORD_W  = 10,
    parameter int   FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    output logic               pix_ce,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic [COORD_W-1:0] current_x,
    output logic [COORD_W-1:0] current_y,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam axis_t H_AXIS  = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam axis_t V_AXIS  = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int    H_TOTAL = axis_total(H_AXIS);
    localparam int    V_TOTAL = axis_total(V_AXIS);
    localparam int    HS_BEG  = H_ACTIVE + H_FP;
    localparam int    HS_END  = HS_BEG + H_SYNC;
    localparam int    VS_BEG  = V_ACTIVE + V_FP;
    localparam int    VS_END  = VS_BEG + V_SYNC;

    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] VB_PREV = COORD_W'(V_ACTIVE - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("video_timing_gen: CLK_DIV must be at least 1");
    end
    if ((64'd1 << COORD_W) < 64'(H_TOTAL) || (64'd1 << COORD_W) < 64'(V_TOTAL)) begin : g_bad_coord
        $error("video_timing_gen: COORD_W too small for the raster totals");
    end

    logic               tick;
    logic               h_wrap;
    logic               v_wrap;
    logic [COORD_W-1:0] x_n;
    logic [COORD_W-1:0] y_n;

    pixel_ce_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .tick   (tick),
        .pix_ce (pix_ce)
    );

    assign h_wrap = current_x == H_LAST;
    assign v_wrap = current_y == V_LAST;

    // Dropping enable steers the next position to the origin, so the decode yields the reset values.
    always_comb begin
        x_n = !enable ? '0 : tick ? (h_wrap ? '0 : current_x + 1'b1) : current_x;
        y_n = !enable ? '0 : (tick && h_wrap) ? (v_wrap ? '0 : current_y + 1'b1) : current_y;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            current_x    <= '0;
            current_y    <= '0;
            hs           <= ~HS_ACT;
            vs           <= ~VS_ACT;
            blank        <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            current_x    <= x_n;
            current_y    <= y_n;
            hs           <= (int'(x_n) >= HS_BEG && int'(x_n) < HS_END) ? HS_ACT : ~HS_ACT;
            vs           <= (int'(y_n) >= VS_BEG && int'(y_n) < VS_END) ? VS_ACT : ~VS_ACT;
            blank        <= int'(x_n) >= H_ACTIVE || int'(y_n) >= V_ACTIVE;
            line_start   <= tick && h_wrap;
            frame_start  <= tick && h_wrap && v_wrap;
            vblank_start <= tick && h_wrap && current_y == VB_PREV;
        end
    end

    // Held across enable drops; only a real reset clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            frame_count <= '0;
        else if (tick && h_wrap && v_wrap)
            frame_count <= frame_count + 1'b1;
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized scoreboard bench for video_timing_gen on the 8x6 test raster.
// Two instances share stimulus: CLK_DIV=1 with high polarities and a 2-bit frame counter, CLK_DIV=3 with low polarities.
module tb_video_timing_gen;

    localparam int H = 8;
    localparam int V = 6;
    localparam int F = H * V;

    typedef struct packed {
        logic        pce;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        ls;
        logic        fs;
        logic        vbs;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [15:0] fc;
    } rec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pce, hs, vs, blank, ls, fs, vbs;
    logic [3:0]  xs [2];
    logic [3:0]  ys [2];
    logic [1:0]  fc0;
    logic [15:0] fc1;

    int   checks = 0;
    int   errors = 0;
    int   n [2];
    int   base [2];
    rec_t q [2][$];

    always #5 clk = ~clk;

    video_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_ACT(1'b1), .VS_ACT(1'b1), .COORD_W(4), .FRAME_W(2)
    ) dut0 (
        .clk(clk), .resetn(resetn), .enable(enable), .pix_ce(pce[0]), .hs(hs[0]), .vs(vs[0]),
        .blank(blank[0]), .current_x(xs[0]), .current_y(ys[0]), .line_start(ls[0]),
        .frame_start(fs[0]), .vblank_start(vbs[0]), .frame_count(fc0)
    );

    video_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_ACT(1'b0), .VS_ACT(1'b0), .COORD_W(4), .FRAME_W(16)
    ) dut1 (
        .clk(clk), .resetn(resetn), .enable(enable), .pix_ce(pce[1]), .hs(hs[1]), .vs(vs[1]),
        .blank(blank[1]), .current_x(xs[1]), .current_y(ys[1]), .line_start(ls[1]),
        .frame_start(fs[1]), .vblank_start(vbs[1]), .frame_count(fc1)
    );

    function automatic int dv(int i);
        return i == 0 ? 1 : 3;
    endfunction

    function automatic int fw(int i);
        return i == 0 ? 2 : 16;
    endfunction

    // Reference: after nn enabled clocks since the last restart, nn/CLK_DIV pixels have elapsed.
    function automatic rec_t model_out(int i, int nn, int bb);
        rec_t r;
        int   t  = nn / dv(i);
        int   px = t % H;
        int   py = (t / H) % V;
        logic a  = (i == 0);
        logic tk = nn > 0 && nn % dv(i) == 0;
        r.pce   = tk;
        r.x     = 4'(px);
        r.y     = 4'(py);
        r.hs    = (px >= 5 && px < 7) ? a : !a;
        r.vs    = (py == 4) ? a : !a;
        r.blank = px >= 4 || py >= 3;
        r.ls    = tk && px == 0;
        r.fs    = tk && px == 0 && py == 0;
        r.vbs   = tk && px == 0 && py == 3;
        r.fc    = 16'((bb + t / F) % (1 << fw(i)));
        return r;
    endfunction

    function automatic rec_t got(int i);
        rec_t r;
        r.pce   = pce[i];
        r.hs    = hs[i];
        r.vs    = vs[i];
        r.blank = blank[i];
        r.ls    = ls[i];
        r.fs    = fs[i];
        r.vbs   = vbs[i];
        r.x     = xs[i];
        r.y     = ys[i];
        r.fc    = i == 0 ? 16'(fc0) : fc1;
        return r;
    endfunction

    function automatic string fmt(rec_t r);
        return $sformatf("pce=%0b hs=%0b vs=%0b blank=%0b x=%0d y=%0d ls=%0b fs=%0b vbs=%0b fc=%0d",
                         r.pce, r.hs, r.vs, r.blank, r.x, r.y, r.ls, r.fs, r.vbs, r.fc);
    endfunction

    task automatic check_rec(input string name, input rec_t g, input rec_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got {%s} expected {%s}", name, fmt(g), fmt(e));
        end
    endtask

    task automatic step(input logic rn, input logic en);
        resetn = rn;
        enable = en;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rn) begin
                n[i] = 0;
                base[i] = 0;
            end else if (!en) begin
                base[i] = (base[i] + (n[i] / dv(i)) / F) % (1 << fw(i));
                n[i] = 0;
            end else begin
                n[i]++;
            end
            q[i].push_back(model_out(i, n[i], base[i]));
        end
        #2;
    endtask

    task automatic async_reset_check(input string name);
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n[i] = 0;
            base[i] = 0;
        end
        #1;
        for (int i = 0; i < 2; i++)
            check_rec($sformatf("%s_inst%0d", name, i), got(i), model_out(i, 0, 0));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (q[i].size() > 0)
                check_rec($sformatf("scoreboard_inst%0d_t%0t", i, $time), got(i), q[i].pop_front());
        end
    end

    initial begin
        bit hit;
        #1;
        async_reset_check("power_on_reset");
        repeat (3) step(1'b0, 1'b0);
        repeat (300) step(1'b1, 1'b1);
        // Walk instance 0 to pixel (3,2) and drop enable there.
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            step(1'b1, 1'b1);
            hit = (n[0] % H == 3) && ((n[0] / H) % V == 2);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reach_3_2 got reached=0 expected reached=1");
        end
        repeat (4) step(1'b1, 1'b0);
        repeat (120) step(1'b1, 1'b1);
        for (int k = 0; k < 2000; k++)
            step(1'b1, $urandom_range(0, 39) != 0);
        repeat (13) step(1'b1, 1'b1);
        @(negedge clk);
        #2;
        async_reset_check("mid_line_reset");
        repeat (2) step(1'b0, 1'b1);
        repeat (200) step(1'b1, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d expected pending=0", q[0].size() + q[1].size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
